// File: rtl/legv8_mem_access_unit.sv
// Load/store unit between the LEGv8 datapath and data RAM: request/response handshake,
// lane-aligned RAM strobes with an ack timeout, and extension of returned load data.
module legv8_mem_access_unit #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  input  logic                    req_write_i,
  input  logic [1:0]              req_size_i,
  input  logic                    req_signed_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  output logic                    req_ready_o,
  output logic                    resp_valid_o,
  output logic                    resp_fault_o,
  output logic [DATA_WIDTH-1:0]   resp_rdata_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_read_o,
  output logic                    mem_write_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_ack_i
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    req_ready_q, req_ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_fault_q, resp_fault_d;
  logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [BE_W-1:0]         mem_be_q, mem_be_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [1:0]              size_q, size_d;
  logic                    signed_q, signed_d;
  logic [OFF_W-1:0]        off_q, off_d;

  logic                    req_fault;
  logic [BE_W-1:0]         store_be;
  logic [DATA_WIDTH-1:0]   store_data;
  logic [DATA_WIDTH-1:0]   load_shifted;
  logic [DATA_WIDTH-1:0]   load_mask;
  logic                    load_sign;
  logic [DATA_WIDTH-1:0]   load_data;

  // Request decode: alignment/size legality, byte enables and replicated store data
  always_comb begin
    req_fault   = 1'b0;
    store_be    = '0;
    store_data  = '0;
    case (req_size_i)
      2'd0: begin
        store_be   = BE_W'(8'h01);
        store_data = {(DATA_WIDTH/8){req_wdata_i[7:0]}};
      end
      2'd1: begin
        req_fault  = req_addr_i[0];
        store_be   = BE_W'(8'h03);
        store_data = {(DATA_WIDTH/16){req_wdata_i[15:0]}};
      end
      2'd2: begin
        req_fault  = |req_addr_i[1:0];
        store_be   = BE_W'(8'h0F);
        store_data = {(DATA_WIDTH/32){req_wdata_i[31:0]}};
      end
      default: begin
        req_fault  = (|req_addr_i[2:0]) || (DATA_WIDTH == 32);
        store_be   = BE_W'(8'hFF);
        store_data = req_wdata_i;
      end
    endcase
    store_be = store_be << req_addr_i[OFF_W-1:0];
  end

  // Load field extraction from the lane selected by the latched offset
  always_comb begin
    load_shifted = mem_rdata_i >> {off_q, 3'b000};
    case (size_q)
      2'd0:    begin load_mask = DATA_WIDTH'(8'hFF);         load_sign = load_shifted[7];  end
      2'd1:    begin load_mask = DATA_WIDTH'(16'hFFFF);      load_sign = load_shifted[15]; end
      2'd2:    begin load_mask = DATA_WIDTH'(32'hFFFF_FFFF); load_sign = load_shifted[31]; end
      default: begin load_mask = '1; load_sign = load_shifted[DATA_WIDTH-1]; end
    endcase
    load_data = (load_shifted & load_mask) | ((signed_q && load_sign) ? ~load_mask : '0);
  end

  always_comb begin
    state_d      = state_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_fault_d = 1'b0;
    resp_rdata_d = '0;
    mem_addr_d   = mem_addr_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid_i && req_ready_q) begin
          req_ready_d = 1'b0;
          write_d     = req_write_i;
          size_d      = req_size_i;
          signed_d    = req_signed_i;
          off_d       = req_addr_i[OFF_W-1:0];
          if (req_fault) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else begin
            state_d     = ACCESS;
            cnt_d       = '0;
            mem_read_d  = !req_write_i;
            mem_write_d = req_write_i;
            mem_addr_d  = {req_addr_i[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
            mem_be_d    = req_write_i ? store_be : '1;
            mem_wdata_d = req_write_i ? store_data : '0;
          end
        end
      end
      ACCESS: begin
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        // Ack takes priority over a timeout landing on the same edge
        if (mem_ack_i) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = write_q ? '0 : load_data;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_fault_d = 1'b1;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_addr_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      off_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_fault_o = resp_fault_q;
  assign resp_rdata_o = resp_rdata_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_be_o     = mem_be_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_legv8_mem_access_unit.sv
// Directed bench for legv8_mem_access_unit: 64-bit instance for the main paths plus a
// 32-bit instance for the width-dependent size fault and lane placement.
module tb_legv8_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_fault;
  logic [63:0] resp_rdata;
  logic [31:0] mem_addr;
  logic        mem_read, mem_write;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  logic        n_valid = 1'b0, n_write = 1'b0, n_signed = 1'b0;
  logic [1:0]  n_size = 2'd0;
  logic [31:0] n_addr = '0;
  logic [31:0] n_wdata = '0;
  logic        n_ready, n_resp_valid, n_resp_fault;
  logic [31:0] n_resp_rdata;
  logic [31:0] n_mem_addr;
  logic        n_mem_read, n_mem_write;
  logic [3:0]  n_mem_be;
  logic [31:0] n_mem_wdata;
  logic [31:0] n_mem_rdata = '0;
  logic        n_mem_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  legv8_mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_size_i(req_size),
    .req_signed_i(req_signed), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_ready_o(req_ready), .resp_valid_o(resp_valid), .resp_fault_o(resp_fault),
    .resp_rdata_o(resp_rdata), .mem_addr_o(mem_addr), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack)
  );

  legv8_mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut32 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(n_valid), .req_write_i(n_write), .req_size_i(n_size),
    .req_signed_i(n_signed), .req_addr_i(n_addr), .req_wdata_i(n_wdata),
    .req_ready_o(n_ready), .resp_valid_o(n_resp_valid), .resp_fault_o(n_resp_fault),
    .resp_rdata_o(n_resp_rdata), .mem_addr_o(n_mem_addr), .mem_read_o(n_mem_read),
    .mem_write_o(n_mem_write), .mem_be_o(n_mem_be), .mem_wdata_o(n_mem_wdata),
    .mem_rdata_i(n_mem_rdata), .mem_ack_i(n_mem_ack)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  // Present one request at a negedge; returns in the first cycle after acceptance
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [63:0] wd);
    $display("txn %s size=%0d signed=%0b addr=0x%h wdata=0x%h",
             w ? "store" : "load", sz, sg, a, wd);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(negedge clk);
    req_valid  = 1'b0;
    check("ready_drop", {63'd0, req_ready}, 64'd0);
  endtask

  // Hold ack low for 'delay' access cycles, then ack with 'rd' and check the response
  task automatic complete(input string tag, input int delay, input logic [63:0] rd,
                          input logic [63:0] exp_rdata);
    repeat (delay) @(negedge clk);
    mem_rdata = rd;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd1);
    check({tag, "_resp_fault"}, {63'd0, resp_fault}, 64'd0);
    check({tag, "_resp_rdata"}, resp_rdata, exp_rdata);
    check({tag, "_strobes_off"}, {62'd0, mem_read, mem_write}, 64'd0);
    @(negedge clk);
    check({tag, "_ready_back"}, {62'd0, req_ready, resp_valid}, 64'd2);
  endtask

  initial begin
    int hi_cnt;
    int wr_cnt;

    repeat (3) @(negedge clk);
    check("rst_outputs", {mem_addr, 26'd0, req_ready, resp_valid, resp_fault,
                          mem_read, mem_write, |mem_be}, 64'd0);
    rst_n = 1'b1;
    #1 check("rst_ready_before_edge", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    check("rst_ready_after_edge", {63'd0, req_ready}, 64'd1);

    // Reset asserted mid-access drops everything at once
    issue(1'b0, 2'd3, 1'b0, 32'h0000_0020, 64'd0);
    check("midrst_read_on", {63'd0, mem_read}, 64'd1);
    #2 rst_n = 1'b0;
    #1 check("midrst_async", {61'd0, mem_read, resp_valid, req_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst_ready_hold", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    check("midrst_ready_up", {62'd0, req_ready, mem_read}, 64'd2);

    // Dword store
    issue(1'b1, 2'd3, 1'b0, 32'h0000_0018, 64'h0123_4567_89AB_CDEF);
    check("sd_strobes", {62'd0, mem_read, mem_write}, 64'd1);
    check("sd_addr", {32'd0, mem_addr}, 64'h18);
    check("sd_be", {56'd0, mem_be}, 64'hFF);
    check("sd_wdata", mem_wdata, 64'h0123_4567_89AB_CDEF);
    complete("sd", 1, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0);

    // Byte store, upper wdata bits must not leak
    issue(1'b1, 2'd0, 1'b0, 32'h0000_001B, 64'h1122_3344_5566_77A5);
    check("sb_addr", {32'd0, mem_addr}, 64'h18);
    check("sb_be", {56'd0, mem_be}, 64'h08);
    check("sb_wdata", mem_wdata, 64'hA5A5_A5A5_A5A5_A5A5);
    complete("sb", 0, 64'd0, 64'd0);

    // Half store in lane 2
    issue(1'b1, 2'd1, 1'b0, 32'h0000_0012, 64'h0000_0000_0000_BEEF);
    check("sh_addr", {32'd0, mem_addr}, 64'h10);
    check("sh_be", {56'd0, mem_be}, 64'h0C);
    check("sh_wdata", mem_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
    complete("sh", 0, 64'd0, 64'd0);

    // Half loads, signed and unsigned
    issue(1'b0, 2'd1, 1'b1, 32'h0000_001E, 64'd0);
    check("lhs_strobes", {62'd0, mem_read, mem_write}, 64'd2);
    check("lhs_addr", {32'd0, mem_addr}, 64'h18);
    check("lhs_be", {56'd0, mem_be}, 64'hFF);
    complete("lhs", 0, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
    issue(1'b0, 2'd1, 1'b0, 32'h0000_001E, 64'd0);
    complete("lhu", 0, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001);

    // Word signed, byte unsigned, dword with signed ignored
    issue(1'b0, 2'd2, 1'b1, 32'h0000_001C, 64'd0);
    complete("lws", 2, 64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF);
    issue(1'b0, 2'd0, 1'b0, 32'h0000_0019, 64'd0);
    complete("lbu", 0, 64'h0000_0000_0000_F200, 64'h0000_0000_0000_00F2);
    issue(1'b0, 2'd3, 1'b1, 32'h0000_0028, 64'd0);
    complete("lds", 0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);

    // Ack in the final allowed cycle beats the timeout
    issue(1'b0, 2'd0, 1'b1, 32'h0000_0007, 64'd0);
    complete("ack_last", 7, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);

    // Misaligned word load and misaligned half store fault with no strobes
    issue(1'b0, 2'd2, 1'b0, 32'h0000_001A, 64'd0);
    check("mis_w_resp", {61'd0, resp_valid, resp_fault, mem_read}, 64'd6);
    check("mis_w_rdata", resp_rdata, 64'd0);
    @(negedge clk);
    check("mis_w_idle", {62'd0, req_ready, resp_valid}, 64'd2);
    issue(1'b1, 2'd1, 1'b0, 32'h0000_0011, 64'hFFFF);
    check("mis_h_resp", {61'd0, resp_valid, resp_fault, mem_write}, 64'd6);
    @(negedge clk);

    // Ack while idle is ignored
    mem_ack = 1'b1;
    mem_rdata = 64'h1234;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = '0;
    check("idle_ack", {61'd0, resp_valid, mem_read, req_ready}, 64'd1);

    // Timeout with requests toggled while busy
    issue(1'b0, 2'd3, 1'b0, 32'h0000_0040, 64'd0);
    hi_cnt = 0;
    wr_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!mem_read) break;
      hi_cnt++;
      if (mem_write) wr_cnt++;
      req_valid = ~req_valid;
      req_write = 1'b1;
      req_size  = 2'd3;
      req_addr  = 32'h0000_0080;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("to_read_cycles", 64'(hi_cnt), 64'd8);
    check("to_no_write", 64'(wr_cnt), 64'd0);
    check("to_resp", {62'd0, resp_valid, resp_fault}, 64'd3);
    check("to_rdata", resp_rdata, 64'd0);
    @(negedge clk);
    check("to_idle", {61'd0, req_ready, mem_write, resp_valid}, 64'd4);
    @(negedge clk);
    check("to_no_second", {62'd0, mem_write, mem_read}, 64'd0);

    // 32-bit instance: dword illegal, half store lane placement
    $display("txn32 load size=3 addr=0x00000000");
    n_valid = 1'b1; n_write = 1'b0; n_size = 2'd3; n_addr = 32'h0;
    @(negedge clk);
    n_valid = 1'b0;
    check("w32_dword_fault", {61'd0, n_resp_valid, n_resp_fault, n_mem_read}, 64'd6);
    @(negedge clk);
    check("w32_ready", {63'd0, n_ready}, 64'd1);
    $display("txn32 store size=1 addr=0x00000006 wdata=0x0000beef");
    n_valid = 1'b1; n_write = 1'b1; n_size = 2'd1; n_addr = 32'h6; n_wdata = 32'h0000_BEEF;
    @(negedge clk);
    n_valid = 1'b0;
    check("w32_sh_strobe", {63'd0, n_mem_write}, 64'd1);
    check("w32_sh_addr", {32'd0, n_mem_addr}, 64'h4);
    check("w32_sh_be", {60'd0, n_mem_be}, 64'hC);
    check("w32_sh_wdata", {32'd0, n_mem_wdata}, 64'hBEEF_BEEF);
    n_mem_ack = 1'b1;
    @(negedge clk);
    n_mem_ack = 1'b0;
    check("w32_sh_resp", {61'd0, n_resp_valid, n_resp_fault, n_mem_write}, 64'd4);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
